// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT = 16;

    localparam int FD_W = 96;
    localparam int DE_W = 130;
    localparam int EM_W = 110;
    localparam int MW_W = 72;

    // Bubbles: every write-enable low, so all-zero bundles are harmless.
    localparam logic [FD_W-1:0] FD_NOP = '0;
    localparam logic [DE_W-1:0] DE_NOP = '0;
    localparam logic [EM_W-1:0] EM_NOP = '0;
    localparam logic [MW_W-1:0] MW_NOP = '0;

    function automatic logic [1:0] entry_count(input state_t s);
        case (s)
            BUSY:    entry_count = 2'd1;
            FULL:    entry_count = 2'd2;
            default: entry_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with a small variable increment, cleared only by reset.
module pipe_sat_cnt #(
    parameter int W     = 16,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);

    logic [W:0] sum;

    assign sum = {1'b0, count} + (W+1)'(inc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (sum[W]) begin
            count <= '1;
        end else begin
            count <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush and 2-entry skid buffer.
// Optional statistics counters are enabled with PIPE_STAGE_STATS_EN.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 130,
    parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
    parameter int               CNT_W     = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] drop_cnt
`endif
);

    state_t           state, next_state;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    assign out_valid = (state != EMPTY);
    assign out_data  = out_valid ? main_q : NOP_VALUE;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        next_state = state;
        main_d     = main_q;
        skid_d     = skid_q;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    main_d     = in_data;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d     = in_data;
                    next_state = FULL;
                end else if (out_fire) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d     = skid_q;
                    next_state = BUSY;
                end
            end
            default: next_state = EMPTY;
        endcase
        if (flush) begin
            next_state = EMPTY;
        end
    end

    // in_ready is its own flop so no upstream path ever sees out_ready combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            main_q   <= NOP_VALUE;
            skid_q   <= NOP_VALUE;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            main_q   <= main_d;
            skid_q   <= skid_d;
            in_ready <= (next_state != FULL);
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [1:0] stall_inc, drop_inc;

    assign stall_inc = {1'b0, out_valid & ~out_ready};
    assign drop_inc  = flush ? entry_count(state) : 2'd0;

    pipe_sat_cnt #(.W(CNT_W), .INC_W(2)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_cnt #(.W(CNT_W), .INC_W(2)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_inc),
        .count (drop_cnt)
    );
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a queue-based reference model.
// Counter checks are compiled in when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_skid;

    localparam int               W     = 16;
    localparam logic [W-1:0]     NOP   = 16'h0F0F;
    localparam int               CW    = 4;
    localparam int               CMAX  = (1 << CW) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] drop_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] model_q[$];
    int           stall_m = 0;
    int           drop_m  = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Checks the current outputs against the model, then advances both by one clock.
    task automatic apply_stimulus(input logic iv, input logic [W-1:0] id,
                                  input logic ordy, input logic fl);
        logic         exp_valid, exp_ready;
        logic [W-1:0] exp_data;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_valid = (model_q.size() != 0);
        exp_ready = (model_q.size() < 2);
        exp_data  = exp_valid ? model_q[0] : NOP;
        check_output("out_valid", 32'(out_valid), 32'(exp_valid));
        check_output("out_data",  32'(out_data),  32'(exp_data));
        check_output("in_ready",  32'(in_ready),  32'(exp_ready));
`ifdef PIPE_STAGE_STATS_EN
        check_output("stall_cnt", 32'(stall_cnt), 32'(stall_m));
        check_output("drop_cnt",  32'(drop_cnt),  32'(drop_m));
`endif
        @(posedge clk);
        stall_m = sat(stall_m + ((exp_valid && !ordy) ? 1 : 0));
        if (fl) begin
            drop_m = sat(drop_m + model_q.size());
            model_q.delete();
        end else begin
            if (exp_valid && ordy) void'(model_q.pop_front());
            if (iv && exp_ready) model_q.push_back(id);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_output({tag, "_out_data"},  32'(out_data),  32'(NOP));
        check_output({tag, "_in_ready"},  32'(in_ready),  32'd1);
    endtask

    task automatic model_reset();
        model_q.delete();
        stall_m = 0;
        drop_m  = 0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        $display("[TB] start");
        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        model_reset();

        // Streaming at full rate
        apply_stimulus(1'b1, 16'h00A1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 16'h00A2, 1'b1, 1'b0);
        apply_stimulus(1'b1, 16'h00A3, 1'b1, 1'b0);
        apply_stimulus(1'b1, 16'h00A4, 1'b1, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure fills the skid, then drains in order
        apply_stimulus(1'b1, 16'h0011, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0022, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0033, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0033, 1'b1, 1'b0);
        apply_stimulus(1'b1, 16'h0033, 1'b1, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush while full, with a competing input that must be dropped
        apply_stimulus(1'b1, 16'h0011, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0022, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0055, 1'b1, 1'b1);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush with nothing held
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush and reset together: reset wins
        apply_stimulus(1'b1, 16'h0066, 1'b0, 1'b0);
        flush = 1'b1;
        reset = 1'b1;
        #1;
        check_reset_state("flush_reset");
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        model_reset();
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle while full
        apply_stimulus(1'b1, 16'h0011, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0022, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);

        // Long stall drives the stall counter into saturation
        apply_stimulus(1'b1, 16'h0077, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        end
`ifdef PIPE_STAGE_STATS_EN
        check_output("stall_sat", 32'(stall_cnt), 32'(CMAX));
`endif
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(0, 3) != 0), W'($urandom),
                           ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
